// File: rtl/loop_fetch_ctrl_if.sv
// Fetch/loop-sequencer bus: instruction and data-cell inputs plus stall, and
// the fetch address, skip status, nesting depth and loop-stack status.
// master = the sequencer, slave = the memory/datapath side that feeds it.
interface loop_fetch_ctrl_if #(
   parameter int PCWidth    = 16,
   parameter int StackDepth = 16
);
   localparam int LevelWidth = $clog2(StackDepth) + 1;

   logic [8:0]            instruction;
   logic [7:0]            working;
   logic                  stall;
   logic [PCWidth-1:0]    pc;
   logic                  searching;
   logic [PCWidth-1:0]    branch_tracking_out;
   logic [LevelWidth-1:0] stack_level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      input  instruction, working, stall,
      output pc, searching, branch_tracking_out, stack_level, overflow, underflow
   );

   modport slave (
      output instruction, working, stall,
      input  pc, searching, branch_tracking_out, stack_level, overflow, underflow
   );
endinterface

// File: rtl/loop_fetch_ctrl.sv
// Program counter and loop-entry LIFO for CBF/CBB loops. In RUN a taken CBF
// records its own address; a taken CBB jumps back to that address + 1. An
// unentered CBF switches to SKIP, which walks forward counting nested CBF/CBB
// pairs until the matching CBB. The nesting depth is exported to branch_ctrl.
module loop_fetch_ctrl #(
   parameter int         PCWidth    = 16,
   parameter int         StackDepth = 16,
   parameter logic [8:0] OpCbf      = 9'h1F0,
   parameter logic [8:0] OpCbb      = 9'h1F1
) (
   input  logic             clk,
   input  logic             reset,
   loop_fetch_ctrl_if.master bus
);
   localparam int LevelWidth = $clog2(StackDepth) + 1;
   localparam int IdxWidth   = $clog2(StackDepth);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_SKIP = 1'b1
   } state_t;

   state_t                state_r;
   logic [PCWidth-1:0]    pc_r;
   logic [PCWidth-1:0]    depth_r;
   logic [LevelWidth-1:0] level_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic [PCWidth-1:0]    stack_r [StackDepth];

   logic                  is_cbf_s;
   logic                  is_cbb_s;
   logic                  work_nz_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  push_s;
   logic [LevelWidth-1:0] level_m1_s;
   logic [IdxWidth-1:0]   top_idx_s;
   logic [PCWidth-1:0]    top_s;
   logic [PCWidth-1:0]    pc_inc_s;

   // Decode the presented opcode and derive stack/pc helper values.
   always_comb begin
      is_cbf_s   = (bus.instruction == OpCbf);
      is_cbb_s   = (bus.instruction == OpCbb);
      work_nz_s  = (bus.working != 8'd0);
      full_s     = (level_r == LevelWidth'(StackDepth));
      empty_s    = (level_r == LevelWidth'(0));
      level_m1_s = level_r - LevelWidth'(1);
      top_idx_s  = level_m1_s[IdxWidth-1:0];
      top_s      = stack_r[top_idx_s];
      pc_inc_s   = pc_r + PCWidth'(1);
      // Entry write only for an accepted push; a push into a full stack is dropped.
      push_s     = !bus.stall && (state_r == ST_RUN) && is_cbf_s && work_nz_s && !full_s;
   end

   // Loop-entry storage; contents need no reset because stack_level qualifies them.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         stack_r[level_r[IdxWidth-1:0]] <= pc_r;
      end
   end

   // Sequencer FSM: pc, run/skip state, nesting depth, stack level and sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_RUN;
         pc_r        <= '0;
         depth_r     <= '0;
         level_r     <= '0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (!bus.stall) begin
         // Every non-jump case falls through to the sequential address.
         pc_r <= pc_inc_s;
         case (state_r)
            ST_RUN: begin
               if (is_cbf_s) begin
                  if (work_nz_s) begin
                     if (full_s) begin
                        overflow_r <= 1'b1;
                     end else begin
                        level_r <= level_r + LevelWidth'(1);
                     end
                  end else begin
                     state_r <= ST_SKIP;
                     depth_r <= '0;
                  end
               end else if (is_cbb_s) begin
                  if (empty_s) begin
                     underflow_r <= 1'b1;
                  end else if (work_nz_s) begin
                     // Loop again: resume at the instruction after the CBF.
                     pc_r <= top_s + PCWidth'(1);
                  end else begin
                     level_r <= level_m1_s;
                  end
               end
            end
            ST_SKIP: begin
               if (is_cbf_s) begin
                  if (depth_r != {PCWidth{1'b1}}) begin
                     depth_r <= depth_r + PCWidth'(1);
                  end
               end else if (is_cbb_s) begin
                  if (depth_r == '0) begin
                     state_r <= ST_RUN;
                  end else begin
                     depth_r <= depth_r - PCWidth'(1);
                  end
               end
            end
            default: begin
               state_r <= ST_RUN;
               depth_r <= '0;
            end
         endcase
      end
   end

   assign bus.pc                  = pc_r;
   assign bus.searching           = (state_r == ST_SKIP);
   assign bus.branch_tracking_out = depth_r;
   assign bus.stack_level         = level_r;
   assign bus.overflow            = overflow_r;
   assign bus.underflow           = underflow_r;
endmodule

// File: tb/tb_loop_fetch_ctrl.sv
// Scoreboard bench for loop_fetch_ctrl: a queue-based loop-stack model predicts
// the state after every clock; a monitor compares it with the DUT outputs.
module tb_loop_fetch_ctrl;
   localparam int         PW   = 5;
   localparam int         SD   = 4;
   localparam int         PMOD = 1 << PW;
   localparam logic [8:0] CBF  = 9'h1F0;
   localparam logic [8:0] CBB  = 9'h1F1;
   localparam logic [8:0] NOP  = 9'h001;

   logic clk;
   logic reset;

   loop_fetch_ctrl_if #(.PCWidth(PW), .StackDepth(SD)) bus ();

   loop_fetch_ctrl #(.PCWidth(PW), .StackDepth(SD), .OpCbf(CBF), .OpCbb(CBB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int pc;
      bit skip;
      int depth;
      int level;
      bit ov;
      bit un;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model state
   int m_pc = 0;
   int m_depth = 0;
   bit m_skip = 1'b0;
   bit m_ov = 1'b0;
   bit m_un = 1'b0;
   int m_stack[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit rst, input logic [8:0] ins, input logic [7:0] w, input bit st);
      int nxt;
      if (rst) begin
         m_pc = 0; m_depth = 0; m_skip = 0; m_ov = 0; m_un = 0;
         m_stack.delete();
      end else if (!st) begin
         nxt = (m_pc + 1) % PMOD;
         if (!m_skip) begin
            if (ins == CBF) begin
               if (w != 0) begin
                  if (m_stack.size() < SD) m_stack.push_back(m_pc);
                  else m_ov = 1;
               end else begin
                  m_skip = 1; m_depth = 0;
               end
               m_pc = nxt;
            end else if (ins == CBB) begin
               if (m_stack.size() == 0) begin
                  m_un = 1; m_pc = nxt;
               end else if (w != 0) begin
                  m_pc = (m_stack[$] + 1) % PMOD;
               end else begin
                  void'(m_stack.pop_back());
                  m_pc = nxt;
               end
            end else begin
               m_pc = nxt;
            end
         end else begin
            if (ins == CBF) begin
               if (m_depth < PMOD - 1) m_depth++;
            end else if (ins == CBB) begin
               if (m_depth == 0) m_skip = 0;
               else m_depth--;
            end
            m_pc = nxt;
         end
      end
   endtask

   task automatic step(input bit rst, input logic [8:0] ins, input logic [7:0] w, input bit st);
      exp_t e;
      @(negedge clk);
      reset           = rst;
      bus.instruction = ins;
      bus.working     = w;
      bus.stall       = st;
      model(rst, ins, w, st);
      e.pc = m_pc; e.skip = m_skip; e.depth = m_depth;
      e.level = m_stack.size(); e.ov = m_ov; e.un = m_un;
      exp_q.push_back(e);
   endtask

   // Monitor: after each active edge, compare DUT outputs with the oldest prediction.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("pc",        int'(bus.pc),                  e.pc);
         check("searching", int'(bus.searching),           int'(e.skip));
         check("depth",     int'(bus.branch_tracking_out), e.depth);
         check("level",     int'(bus.stack_level),         e.level);
         check("overflow",  int'(bus.overflow),            int'(e.ov));
         check("underflow", int'(bus.underflow),           int'(e.un));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [8:0] ins;
      reset = 1'b1; bus.instruction = NOP; bus.working = 8'd0; bus.stall = 1'b0;

      // reset for two cycles, then sequential fetch
      step(1, NOP, 8'd0, 0); step(1, NOP, 8'd0, 0);
      repeat (4) step(0, NOP, 8'd0, 0);
      // taken loop at pc=4, back-branch at pc=7 twice
      step(0, CBF, 8'd5, 0); step(0, NOP, 8'd0, 0); step(0, NOP, 8'd0, 0);
      step(0, CBB, 8'd5, 0); step(0, NOP, 8'd0, 0); step(0, NOP, 8'd0, 0);
      step(0, CBB, 8'd0, 0);

      // nested skip from pc=2
      step(1, NOP, 8'd0, 0); step(0, NOP, 8'd0, 0); step(0, NOP, 8'd0, 0);
      step(0, CBF, 8'd0, 0);
      step(0, CBF, 8'd7, 0); step(0, NOP, 8'd0, 0); step(0, CBF, 8'd0, 0);
      step(0, CBB, 8'd3, 0); step(0, CBB, 8'd0, 0); step(0, CBB, 8'd9, 0);
      step(0, NOP, 8'd0, 0);

      // overflow then drain, then underflow
      step(1, NOP, 8'd0, 0);
      repeat (5) step(0, CBF, 8'd1, 0);
      repeat (4) step(0, CBB, 8'd0, 0);
      step(0, CBB, 8'd0, 0);
      step(0, NOP, 8'd0, 0);

      // stall at depth 2 mid-skip, then reset
      step(1, NOP, 8'd0, 0);
      step(0, CBF, 8'd0, 0); step(0, CBF, 8'd0, 0); step(0, CBF, 8'd0, 0);
      repeat (3) step(0, CBF, 8'd1, 1);
      step(1, CBF, 8'd0, 0);

      // depth saturation and pc wrap
      step(0, CBF, 8'd0, 0);
      repeat (PMOD + 3) step(0, CBF, 8'd0, 0);
      repeat (3) step(0, CBB, 8'd0, 0);
      step(1, NOP, 8'd0, 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 25)      ins = CBF;
         else if (r < 55) ins = CBB;
         else             ins = 9'($urandom_range(0, 255));
         step(($urandom_range(0, 199) == 0),
              ins,
              ($urandom_range(0, 99) < 35) ? 8'd0 : 8'($urandom_range(1, 255)),
              ($urandom_range(0, 99) < 10));
      end

      @(posedge clk);
      #2;
      check("queue_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
